ifstage_fetch: RTL and testbench

Instruction-fetch stage directly upstream of DECSTAGE. It holds the PC, issues word fetches to instruction memory over a req/ready handshake, and registers the returned word as Instr for decode. It computes the next PC as sequential (PC+4) or branch (PC+4+(Immed<<2)), using the sign-extended Immed that DECSTAGE produces. A fetch watchdog flags a memory that never answers.

---
 rtl/ifstage_pkg.sv | 12 +
 rtl/pc_next_unit.sv | 21 ++
 rtl/ifstage_fetch.sv | 103 ++++++++++
 tb/tb_ifstage_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ifstage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and word size.
package ifstage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_ERR  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/pc_next_unit.sv
// Next-PC computation: sequential PC+4 or branch PC+4+(Immed<<2), modulo 2^32.
module pc_next_unit
  import ifstage_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [31:0] Immed,
  input  logic        PC_sel,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;

  always_comb begin
    seq_pc  = PC + WORD_BYTES;
    // Word offset to byte offset; the top two immediate bits fall off.
    br_off  = Immed << 2;
    next_pc = PC_sel ? (seq_pc + br_off) : seq_pc;
  end

endmodule

// File: rtl/ifstage_fetch.sv
// Instruction-fetch stage: holds PC, fetches over a req/ready handshake, registers Instr,
// and trips a sticky watchdog when memory never answers.
module ifstage_fetch
  import ifstage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        PC_sel,
  input  logic        PC_LdEn,
  input  logic [31:0] Immed,
  output logic        Mem_req,
  output logic [31:0] Mem_addr,
  input  logic        Mem_ready,
  input  logic [31:0] Mem_rdata,
  output logic [31:0] Instr,
  output logic        Instr_valid,
  output logic [31:0] PC_out,
  output logic        Fetch_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT - 1);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     next_pc;

  pc_next_unit u_pc_next (
    .PC      (pc_q),
    .Immed   (Immed),
    .PC_sel  (PC_sel),
    .next_pc (next_pc)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_REQ: begin
        // Ready wins over the watchdog limit on the same edge.
        if (Mem_ready) begin
          instr_d = Mem_rdata;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == CntLimit) begin
          valid_d = 1'b0;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (PC_LdEn) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_ERR: begin
        valid_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_ERR;
      end
    endcase
  end

  assign Mem_req     = (state_q == S_REQ) && Reset_n;
  assign Mem_addr    = pc_q;
  assign PC_out      = pc_q;
  assign Instr       = instr_q;
  assign Instr_valid = valid_q;
  assign Fetch_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_ifstage_fetch.sv
// Directed self-checking bench for ifstage_fetch.
module tb_ifstage_fetch;

  logic        Clk;
  logic        Reset_n;
  logic        PC_sel;
  logic        PC_LdEn;
  logic [31:0] Immed;
  logic        Mem_req;
  logic [31:0] Mem_addr;
  logic        Mem_ready;
  logic [31:0] Mem_rdata;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic [31:0] PC_out;
  logic        Fetch_err;

  int checks;
  int failures;

  ifstage_fetch #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .PC_sel      (PC_sel),
    .PC_LdEn     (PC_LdEn),
    .Immed       (Immed),
    .Mem_req     (Mem_req),
    .Mem_addr    (Mem_addr),
    .Mem_ready   (Mem_ready),
    .Mem_rdata   (Mem_rdata),
    .Instr       (Instr),
    .Instr_valid (Instr_valid),
    .PC_out      (PC_out),
    .Fetch_err   (Fetch_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // From PC=0 in S_REQ with a zero-wait memory, walk to S_REQ at PC=8.
  task automatic walk_to_8();
    Mem_ready = 1'b1;
    Mem_rdata = 32'h1111_0000;
    PC_sel    = 1'b0;
    step();
    PC_LdEn = 1'b1;
    step();
    PC_LdEn = 1'b0;
    step();
    PC_LdEn = 1'b1;
    step();
    PC_LdEn = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    Reset_n   = 1'b0;
    PC_sel    = 1'b0;
    PC_LdEn   = 1'b0;
    Immed     = 32'h0;
    Mem_ready = 1'b1;
    Mem_rdata = 32'hE001_0007;
    step();
    step();

    // Reset values; Mem_ready is high but must not be captured.
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_valid", {31'h0, Instr_valid}, 32'h0);
    chk("rst_req", {31'h0, Mem_req}, 32'h0);
    chk("rst_err", {31'h0, Fetch_err}, 32'h0);

    // Zero-wait fetch at PC 0.
    Reset_n = 1'b1;
    #1;
    chk("z_req_pre", {31'h0, Mem_req}, 32'h1);
    chk("z_addr", Mem_addr, 32'h0);
    step();
    chk("z_instr", Instr, 32'hE001_0007);
    chk("z_valid", {31'h0, Instr_valid}, 32'h1);
    chk("z_req_post", {31'h0, Mem_req}, 32'h0);

    // Sequential advance to 4.
    Mem_ready = 1'b0;
    PC_LdEn   = 1'b1;
    PC_sel    = 1'b0;
    step();
    PC_LdEn = 1'b0;
    chk("seq_pc", PC_out, 32'h4);
    chk("seq_valid", {31'h0, Instr_valid}, 32'h0);
    chk("seq_req", {31'h0, Mem_req}, 32'h1);
    chk("seq_addr", Mem_addr, 32'h4);
    chk("seq_instr_kept", Instr, 32'hE001_0007);

    // Fetch at 4, then positive branch: 4 + 4 + (10<<2) = 0x30.
    Mem_ready = 1'b1;
    Mem_rdata = 32'hA5A5_0004;
    step();
    chk("f4_instr", Instr, 32'hA5A5_0004);
    Mem_ready = 1'b0;
    PC_LdEn   = 1'b1;
    PC_sel    = 1'b1;
    Immed     = 32'd10;
    step();
    chk("brpos_pc", PC_out, 32'h30);

    // Wait states with PC_LdEn held high: PC must stay put.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_valid", {31'h0, Instr_valid}, 32'h0);
    end
    chk("wait_pc", PC_out, 32'h30);
    PC_LdEn   = 1'b0;
    Mem_ready = 1'b1;
    Mem_rdata = 32'hCAFE_0030;
    step();
    chk("wait_rise_valid", {31'h0, Instr_valid}, 32'h1);
    chk("wait_rise_instr", Instr, 32'hCAFE_0030);
    chk("wait_rise_pc", PC_out, 32'h30);

    // Async reset mid-wait at PC 8 with Mem_ready pending.
    Reset_n = 1'b0;
    #1;
    Reset_n = 1'b1;
    walk_to_8();
    chk("ar_pc_pre", PC_out, 32'h8);
    chk("ar_req_pre", {31'h0, Mem_req}, 32'h1);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("ar_pc", PC_out, 32'h0);
    chk("ar_valid", {31'h0, Instr_valid}, 32'h0);
    chk("ar_req", {31'h0, Mem_req}, 32'h0);
    step();
    chk("ar_instr", Instr, 32'h0);

    // Negative branch from 8: 8 + 4 - 24 = 0xFFFF_FFF4.
    Reset_n = 1'b1;
    walk_to_8();
    step();
    chk("f8_valid", {31'h0, Instr_valid}, 32'h1);
    Mem_ready = 1'b0;
    PC_LdEn   = 1'b1;
    PC_sel    = 1'b1;
    Immed     = 32'hFFFF_FFFA;
    step();
    PC_LdEn = 1'b0;
    chk("brneg_pc", PC_out, 32'hFFFF_FFF4);
    chk("brneg_addr", Mem_addr, 32'hFFFF_FFF4);

    // Watchdog: 15 silent edges are tolerated, the 16th trips it.
    for (int i = 0; i < 15; i++) step();
    chk("wd_err_pre", {31'h0, Fetch_err}, 32'h0);
    chk("wd_req_pre", {31'h0, Mem_req}, 32'h1);
    step();
    chk("wd_err", {31'h0, Fetch_err}, 32'h1);
    chk("wd_req", {31'h0, Mem_req}, 32'h0);
    chk("wd_valid", {31'h0, Instr_valid}, 32'h0);
    Mem_ready = 1'b1;
    PC_LdEn   = 1'b1;
    step();
    step();
    PC_LdEn = 1'b0;
    chk("wd_sticky", {31'h0, Fetch_err}, 32'h1);
    chk("wd_sticky_pc", PC_out, 32'hFFFF_FFF4);
    Reset_n = 1'b0;
    #1;
    chk("wd_clear", {31'h0, Fetch_err}, 32'h0);

    // Ready arriving on the limit edge wins over the watchdog.
    step();
    Mem_ready = 1'b0;
    Reset_n   = 1'b1;
    for (int i = 0; i < 15; i++) step();
    Mem_ready = 1'b1;
    Mem_rdata = 32'h0BAD_F00D;
    step();
    chk("lim_err", {31'h0, Fetch_err}, 32'h0);
    chk("lim_valid", {31'h0, Instr_valid}, 32'h1);
    chk("lim_instr", Instr, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
